// File: rtl/reorder_buffer_pkg.sv
// Shared widths and issue_type encodings for the reorder buffer.
// The design's optional feature is selected by the macro ROB_CDB_BYPASS_EN.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif
`ifndef ROB_TYPE_REG
`define ROB_TYPE_REG  2'd0
`define ROB_TYPE_BR   2'd1
`define ROB_TYPE_ST   2'd2
`define ROB_TYPE_HALT 2'd3
`endif

package reorder_buffer_pkg;

    localparam int ROB_W     = `ROB_WIDTH_BIT;
    localparam int ROB_DEPTH = 1 << ROB_W;

    typedef enum logic [1:0] {
        TYPE_REG  = `ROB_TYPE_REG,
        TYPE_BR   = `ROB_TYPE_BR,
        TYPE_ST   = `ROB_TYPE_ST,
        TYPE_HALT = `ROB_TYPE_HALT
    } rob_type_e;

endpackage

// File: rtl/rob_commit_unit.sv
// Retirement decision for the head entry of the reorder buffer.
// Pure combinational; the caller registers the results as one-cycle commit outputs.
module rob_commit_unit
    import reorder_buffer_pkg::*;
(
    input  logic        i_busy,
    input  logic        i_ready,
    input  logic [1:0]  i_type,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_val,
    input  logic        i_pred,
    input  logic        i_taken,
    input  logic [31:0] i_target,
    input  logic        i_halted,
    input  logic        i_flush,
    output logic        o_commit,
    output logic [4:0]  o_reg_id,
    output logic [31:0] o_val,
    output logic        o_store,
    output logic        o_clear,
    output logic [31:0] o_clear_pc,
    output logic        o_halt
);

    rob_type_e w_type;

    assign w_type = rob_type_e'(i_type);

    // Nothing retires once halted or while the flush pulse is clearing the buffer.
    always_comb begin
        o_commit   = 1'b0;
        o_reg_id   = 5'd0;
        o_val      = 32'd0;
        o_store    = 1'b0;
        o_clear    = 1'b0;
        o_clear_pc = 32'd0;
        o_halt     = 1'b0;
        if (i_busy && i_ready && !i_halted && !i_flush) begin
            o_commit = 1'b1;
            case (w_type)
                TYPE_REG: begin
                    o_reg_id = i_rd;
                    o_val    = i_val;
                end
                TYPE_BR: begin
                    o_reg_id = i_rd;
                    o_val    = i_val;
                    if (i_taken != i_pred) begin
                        o_clear    = 1'b1;
                        o_clear_pc = i_target;
                    end
                end
                TYPE_ST:   o_store = 1'b1;
                TYPE_HALT: o_halt  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at issue, captures CDB results, serves operand lookups, retires in order.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the lookup ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 2 ** ROB_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    input  logic [31:0]      issue_pc,
    input  logic             issue_pred_taken,
    input  logic             issue_ready,
    input  logic [31:0]      issue_val,
    output logic             rob_full,
    output logic [ROB_W-1:0] issue_rob_id,
    output logic [4:0]       new_reg_id,
    output logic [ROB_W-1:0] new_ROB_id,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_id,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,
    input  logic [ROB_W-1:0] rs1_id,
    input  logic [ROB_W-1:0] rs2_id,
    output logic             rs1_ready,
    output logic             rs2_ready,
    output logic [31:0]      rs1_val,
    output logic [31:0]      rs2_val,
    output logic [4:0]       write_reg_id,
    output logic [ROB_W-1:0] write_ROB_id,
    output logic [31:0]      write_val,
    output logic             store_commit,
    output logic             clear_flag,
    output logic [31:0]      clear_pc,
    output logic             halt
);

    localparam logic [ROB_W:0] FULL_CNT = (ROB_W + 1)'(DEPTH);

    logic [DEPTH-1:0] r_busy;
    logic             r_ready  [DEPTH];
    logic [1:0]       r_type   [DEPTH];
    logic [4:0]       r_rd     [DEPTH];
    logic [31:0]      r_val    [DEPTH];
    logic             r_pred   [DEPTH];
    logic             r_taken  [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [ROB_W-1:0] r_head;
    logic [ROB_W-1:0] r_tail;
    logic [ROB_W:0]   r_count;

    logic        w_accept;
    logic        w_cdb_hit;
    logic        w_commit;
    logic [4:0]  w_reg_id;
    logic [31:0] w_val;
    logic        w_store;
    logic        w_clear;
    logic [31:0] w_clear_pc;
    logic        w_halt;
    logic        w_unused_pc;

    // The PC travels with the instruction elsewhere; branches resolve their target on the CDB.
    assign w_unused_pc = ^issue_pc;

    assign rob_full     = (r_count == FULL_CNT);
    assign w_accept     = rdy_in && issue_valid && !rob_full && !clear_flag;
    assign w_cdb_hit    = cdb_valid && r_busy[cdb_rob_id];
    assign issue_rob_id = r_tail;
    assign new_ROB_id   = r_tail;
    assign new_reg_id   = w_accept ? issue_rd : 5'd0;

    always_comb begin
        rs1_ready = r_busy[rs1_id] && r_ready[rs1_id];
        rs1_val   = r_val[rs1_id];
        rs2_ready = r_busy[rs2_id] && r_ready[rs2_id];
        rs2_val   = r_val[rs2_id];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_rob_id == rs1_id) && r_busy[rs1_id]) begin
            rs1_ready = 1'b1;
            rs1_val   = cdb_val;
        end
        if (cdb_valid && (cdb_rob_id == rs2_id) && r_busy[rs2_id]) begin
            rs2_ready = 1'b1;
            rs2_val   = cdb_val;
        end
`endif
    end

    rob_commit_unit u_commit (
        .i_busy     (r_busy[r_head]),
        .i_ready    (r_ready[r_head]),
        .i_type     (r_type[r_head]),
        .i_rd       (r_rd[r_head]),
        .i_val      (r_val[r_head]),
        .i_pred     (r_pred[r_head]),
        .i_taken    (r_taken[r_head]),
        .i_target   (r_target[r_head]),
        .i_halted   (halt),
        .i_flush    (clear_flag),
        .o_commit   (w_commit),
        .o_reg_id   (w_reg_id),
        .o_val      (w_val),
        .o_store    (w_store),
        .o_clear    (w_clear),
        .o_clear_pc (w_clear_pc),
        .o_halt     (w_halt)
    );

    // Entry payload needs no reset: every read is qualified by the busy bit.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear_flag) begin
            if (w_accept) begin
                r_ready[r_tail]  <= issue_ready;
                r_type[r_tail]   <= issue_type;
                r_rd[r_tail]     <= issue_rd;
                r_val[r_tail]    <= issue_val;
                r_pred[r_tail]   <= issue_pred_taken;
                r_taken[r_tail]  <= 1'b0;
                r_target[r_tail] <= 32'd0;
            end
            if (w_cdb_hit) begin
                r_ready[cdb_rob_id]  <= 1'b1;
                r_val[cdb_rob_id]    <= cdb_val;
                r_taken[cdb_rob_id]  <= cdb_taken;
                r_target[cdb_rob_id] <= cdb_target;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            write_reg_id <= 5'd0;
            write_ROB_id <= '0;
            write_val    <= 32'd0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
            clear_pc     <= 32'd0;
            halt         <= 1'b0;
        end else if (rdy_in) begin
            write_reg_id <= w_reg_id;
            write_ROB_id <= w_commit ? r_head : '0;
            write_val    <= w_val;
            store_commit <= w_store;
            clear_flag   <= w_clear;
            clear_pc     <= w_clear_pc;
            halt         <= halt | w_halt;
            if (clear_flag) begin
                r_busy  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + ROB_W'(1);
                end
                if (w_accept) begin
                    r_busy[r_tail] <= 1'b1;
                    r_tail         <= r_tail + ROB_W'(1);
                end
                case ({w_accept, w_commit})
                    2'b10:   r_count <= r_count + (ROB_W + 1)'(1);
                    2'b01:   r_count <= r_count - (ROB_W + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
